// File: rtl/line_raster_queue.sv
// line_raster_queue
// Bresenham line rasteriser that takes queued segment requests and writes
// their pixels into a frame-buffer RAM through a ready/valid write port. It
// also runs a queued full-screen clear.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_x0/i_y0/i_x1/i_y1     segment endpoints
//   i_color                 segment colour
//   i_load_fifo             strobe that pushes one segment into the FIFO
//   i_clear_buffer          strobe that requests a full-screen clear
//   o_fifo_full/o_fifo_empty  registered FIFO status
//   o_overflow              one-cycle pulse when a push was dropped (FIFO full)
//   o_waiting               idle, nothing queued and no clear pending
//   o_wr_en/i_wr_ready      write handshake toward the frame buffer
//   o_wr_addr/o_wr_data     write address (y*P_SCREEN_W + x) and pixel value
module line_raster_queue #(
  parameter int P_X_COORD_W       = 11,
  parameter int P_Y_COORD_W       = 11,
  parameter int P_SCREEN_W        = 640,
  parameter int P_SCREEN_H        = 480,
  parameter int P_DATA_W          = 1,
  parameter int P_LOG2_RAM_DEPTH  = 19,
  parameter int P_LOG2_FIFO_DEPTH = 3
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [P_X_COORD_W-1:0]      i_x0,
  input  logic [P_Y_COORD_W-1:0]      i_y0,
  input  logic [P_X_COORD_W-1:0]      i_x1,
  input  logic [P_Y_COORD_W-1:0]      i_y1,
  input  logic [P_DATA_W-1:0]         i_color,
  input  logic                        i_load_fifo,
  input  logic                        i_clear_buffer,
  output logic                        o_fifo_full,
  output logic                        o_fifo_empty,
  output logic                        o_overflow,
  output logic                        o_waiting,
  output logic                        o_wr_en,
  input  logic                        i_wr_ready,
  output logic [P_LOG2_RAM_DEPTH-1:0] o_wr_addr,
  output logic [P_DATA_W-1:0]         o_wr_data
);

  localparam int XW = P_X_COORD_W;
  localparam int YW = P_Y_COORD_W;
  localparam int AW = P_LOG2_RAM_DEPTH;
  localparam int CW = ((XW > YW) ? XW : YW) + 2;
  localparam int FD = 1 << P_LOG2_FIFO_DEPTH;
  localparam int EW = 2 * XW + 2 * YW + P_DATA_W;

  localparam logic [XW:0]   SCREEN_W_X = (XW + 1)'(P_SCREEN_W);
  localparam logic [YW:0]   SCREEN_H_Y = (YW + 1)'(P_SCREEN_H);
  localparam logic [AW-1:0] SCREEN_W_A = AW'(P_SCREEN_W);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(P_SCREEN_W * P_SCREEN_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAW  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------
  // Segment FIFO: array storage with a registered read into head_reg.
  // ---------------------------------------------------------------------
  logic [EW-1:0]                fifo_mem [FD];
  logic [EW-1:0]                head_reg;
  logic [P_LOG2_FIFO_DEPTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [P_LOG2_FIFO_DEPTH:0]   count_reg, count_next;
  logic                         full_reg, empty_reg, overflow_reg;
  logic                         clear_pending_reg;
  logic                         push, pop;

  // A push while full is dropped even if a pop happens in the same cycle,
  // because acceptance only looks at the registered full flag.
  assign push = i_load_fifo & ~full_reg;
  assign pop  = (state_reg == ST_IDLE) & ~clear_pending_reg & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {i_x0, i_y0, i_x1, i_y1, i_color};
    end
  end

  always_ff @(posedge i_clk) begin
    if (pop) begin
      head_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      full_reg     <= (count_next == (P_LOG2_FIFO_DEPTH + 1)'(FD));
      empty_reg    <= (count_next == '0);
      overflow_reg <= i_load_fifo & full_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Head-entry decode and Bresenham set-up values (used in LOAD).
  // ---------------------------------------------------------------------
  logic [XW-1:0]       h_x0, h_x1;
  logic [YW-1:0]       h_y0, h_y1;
  logic [P_DATA_W-1:0] h_color;
  logic signed [CW-1:0] dx_load, dy_load;

  assign {h_x0, h_y0, h_x1, h_y1, h_color} = head_reg;

  always_comb begin
    dx_load = (h_x1 >= h_x0) ? CW'(h_x1 - h_x0) : CW'(h_x0 - h_x1);
    dy_load = (h_y1 >= h_y0) ? -CW'(h_y1 - h_y0) : -CW'(h_y0 - h_y1);
  end

  // ---------------------------------------------------------------------
  // Drawing datapath
  // ---------------------------------------------------------------------
  logic [XW-1:0]        x_reg, x1_reg;
  logic [YW-1:0]        y_reg, y1_reg;
  logic [P_DATA_W-1:0]  color_reg;
  logic signed [CW-1:0] dx_reg, dy_reg, err_reg, err_step;
  logic                 sx_neg_reg, sy_neg_reg;
  logic [AW-1:0]        clr_addr_reg;

  logic signed [CW:0]   e2, dx_ext, dy_ext;
  logic                 step_x, step_y, onscreen, at_end, advance, clr_last;
  logic [AW-1:0]        pix_addr;

  assign e2     = {err_reg, 1'b0};
  assign dx_ext = {dx_reg[CW-1], dx_reg};
  assign dy_ext = {dy_reg[CW-1], dy_reg};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);

  always_comb begin
    err_step = err_reg;
    if (step_x) err_step = err_step + dy_reg;
    if (step_y) err_step = err_step + dx_reg;
  end

  // Coordinates that stepped below zero wrap to large values and are
  // therefore treated as off-screen by the same compare.
  assign onscreen = ({1'b0, x_reg} < SCREEN_W_X) && ({1'b0, y_reg} < SCREEN_H_Y);
  assign at_end   = (x_reg == x1_reg) && (y_reg == y1_reg);
  // Off-screen pixels never wait for the RAM; they are skipped in one cycle.
  assign advance  = ~onscreen | i_wr_ready;
  assign clr_last = (clr_addr_reg == LAST_ADDR);
  // Modular multiply-add: identical to the full-precision result truncated.
  assign pix_addr = AW'(y_reg) * SCREEN_W_A + AW'(x_reg);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_reg             <= '0;
      y_reg             <= '0;
      x1_reg            <= '0;
      y1_reg            <= '0;
      color_reg         <= '0;
      dx_reg            <= '0;
      dy_reg            <= '0;
      err_reg           <= '0;
      sx_neg_reg        <= 1'b0;
      sy_neg_reg        <= 1'b0;
      clr_addr_reg      <= '0;
      clear_pending_reg <= 1'b0;
    end else begin
      // A new request wins over the completion of a running clear.
      if (i_clear_buffer) begin
        clear_pending_reg <= 1'b1;
      end else if (state_reg == ST_CLEAR && i_wr_ready && clr_last) begin
        clear_pending_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          clr_addr_reg <= '0;
        end
        ST_LOAD: begin
          x_reg      <= h_x0;
          y_reg      <= h_y0;
          x1_reg     <= h_x1;
          y1_reg     <= h_y1;
          color_reg  <= h_color;
          dx_reg     <= dx_load;
          dy_reg     <= dy_load;
          err_reg    <= dx_load + dy_load;
          sx_neg_reg <= (h_x1 < h_x0);
          sy_neg_reg <= (h_y1 < h_y0);
        end
        ST_DRAW: begin
          if (advance && !at_end) begin
            err_reg <= err_step;
            if (step_x) x_reg <= sx_neg_reg ? x_reg - 1'b1 : x_reg + 1'b1;
            if (step_y) y_reg <= sy_neg_reg ? y_reg - 1'b1 : y_reg + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (i_wr_ready) clr_addr_reg <= clr_addr_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clear_pending_reg)  state_next = ST_CLEAR;
        else if (!empty_reg)    state_next = ST_LOAD;
      end
      ST_LOAD:  state_next = ST_DRAW;
      ST_DRAW:  if (advance && at_end) state_next = ST_IDLE;
      ST_CLEAR: if (i_wr_ready && clr_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_wr_data = '0;
    case (state_reg)
      ST_DRAW: begin
        o_wr_en   = onscreen;
        o_wr_addr = pix_addr;
        o_wr_data = color_reg;
      end
      ST_CLEAR: begin
        o_wr_en   = 1'b1;
        o_wr_addr = clr_addr_reg;
      end
      default: ;
    endcase
  end

  assign o_fifo_full  = full_reg;
  assign o_fifo_empty = empty_reg;
  assign o_overflow   = overflow_reg;
  assign o_waiting    = (state_reg == ST_IDLE) & empty_reg & ~clear_pending_reg;

endmodule

// File: tb/tb_line_raster_queue.sv
// tb_line_raster_queue
// Scoreboard bench for line_raster_queue: every segment pushed into the DUT
// queues its expected frame-buffer writes; a monitor pops and compares them
// as transfers happen and checks that stalled writes hold their values.
module tb_line_raster_queue;

  localparam int XW = 11;
  localparam int YW = 11;
  localparam int AW = 19;
  localparam int SW = 640;
  localparam int SH = 480;

  logic          clk;
  logic          rst;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic          color;
  logic          load_fifo;
  logic          clear_buffer;
  logic          fifo_full, fifo_empty, overflow, waiting;
  logic          wr_en, wr_ready;
  logic [AW-1:0] wr_addr;
  logic          wr_data;

  line_raster_queue dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_x0           (x0),
    .i_y0           (y0),
    .i_x1           (x1),
    .i_y1           (y1),
    .i_color        (color),
    .i_load_fifo    (load_fifo),
    .i_clear_buffer (clear_buffer),
    .o_fifo_full    (fifo_full),
    .o_fifo_empty   (fifo_empty),
    .o_overflow     (overflow),
    .o_waiting      (waiting),
    .o_wr_en        (wr_en),
    .i_wr_ready     (wr_ready),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int   addr;
    logic data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfers  = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic enq(input int addr, input logic data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference Bresenham walk with on-screen filtering.
  task automatic enq_model(input int ax0, input int ay0, input int ax1, input int ay1, input logic c);
    int px, py, dx, dy, sx, sy, err, e2;
    px  = ax0;
    py  = ay0;
    dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx + dy;
    for (int n = 0; n < 5000; n++) begin
      if (px >= 0 && px < SW && py >= 0 && py < SH) enq(py * SW + px, c);
      if (px == ax1 && py == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the sampling edge.
  task automatic push_seg(input int ax0, input int ay0, input int ax1, input int ay1, input logic c);
    x0        = XW'(ax0);
    y0        = YW'(ay0);
    x1        = XW'(ax1);
    y1        = YW'(ay1);
    color     = c;
    load_fifo = 1'b1;
    @(posedge clk);
    #1;
    load_fifo = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound, output int cycles);
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (waiting) break;
    end
    check_value({tag, "_idle"}, waiting, 1);
    check_value({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: compare each transfer against the scoreboard, check stall hold.
  initial begin
    logic          stall_seen;
    logic [AW-1:0] held_addr;
    logic          held_data;
    exp_t          e;
    stall_seen = 1'b0;
    held_addr  = '0;
    held_data  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          check_value("hold_en", wr_en, 1);
          check_value("hold_addr", wr_addr, held_addr);
          check_value("hold_data", wr_data, held_data);
        end
        stall_seen = wr_en && !wr_ready;
        held_addr  = wr_addr;
        held_data  = wr_data;
        if (wr_en && wr_ready) begin
          n_xfers++;
          if (exp_q.size() == 0) begin
            check_value("sb_has_entry", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_value("wr_addr", wr_addr, e.addr);
            check_value("wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    logic [3:0] bp_pat;
    bp_pat       = 4'b1001;
    rst          = 1'b1;
    x0           = '0;
    y0           = '0;
    x1           = '0;
    y1           = '0;
    color        = 1'b0;
    load_fifo    = 1'b0;
    clear_buffer = 1'b0;
    wr_ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_wr_en", wr_en, 0);
    check_value("rst_wr_addr", wr_addr, 0);
    check_value("rst_wr_data", wr_data, 0);
    check_value("rst_full", fifo_full, 0);
    check_value("rst_empty", fifo_empty, 1);
    check_value("rst_overflow", overflow, 0);
    check_value("rst_waiting", waiting, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Horizontal line with first-write latency
    for (int a = 3210; a <= 3213; a++) enq(a, 1'b1);
    push_seg(10, 5, 13, 5, 1'b1);
    @(negedge clk);
    check_value("lat_e0", wr_en, 0);
    @(negedge clk);
    check_value("lat_e1", wr_en, 0);
    @(negedge clk);
    check_value("lat_e2", wr_en, 1);
    wait_idle("horiz", 50, cyc);

    // Steep reverse line: fixed pixel list, 6 DRAW + 2 bubble cycles
    enq(7 * SW + 3, 1'b1);
    enq(6 * SW + 3, 1'b1);
    enq(5 * SW + 2, 1'b1);
    enq(4 * SW + 2, 1'b1);
    enq(3 * SW + 1, 1'b1);
    enq(2 * SW + 1, 1'b1);
    push_seg(3, 7, 1, 2, 1'b1);
    wait_idle("steep", 50, cyc);
    check_value("steep_cycles", cyc, 8);

    // Back-pressure with ready pattern 1,0,0,1
    base = n_xfers;
    enq_model(0, 0, 9, 4, 1'b1);
    push_seg(0, 0, 9, 4, 1'b1);
    for (int i = 0; i < 400; i++) begin
      wr_ready = bp_pat[i % 4];
      @(posedge clk);
      #1;
      if (waiting && exp_q.size() == 0) break;
    end
    wr_ready = 1'b1;
    check_value("bp_waiting", waiting, 1);
    check_value("bp_xfers", n_xfers - base, 10);

    // FIFO full / overflow with one segment stalled in DRAW
    base     = n_xfers;
    wr_ready = 1'b0;
    enq_model(0, 30, 3, 30, 1'b1);
    push_seg(0, 30, 3, 30, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_value("ff_stalled_en", wr_en, 1);
    check_value("ff_start_empty", fifo_empty, 1);
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) enq_model(k * 4, 40 + k, k * 4 + 1, 40 + k, k[0]);
      push_seg(k * 4, 40 + k, k * 4 + 1, 40 + k, k[0]);
      if (k == 7) check_value("ff_full_after7", fifo_full, 0);
      if (k == 8) begin
        check_value("ff_full_after8", fifo_full, 1);
        check_value("ff_ovf_after8", overflow, 0);
      end
      if (k == 9) check_value("ff_ovf_after9", overflow, 1);
    end
    @(posedge clk);
    #1;
    check_value("ff_ovf_pulse_end", overflow, 0);
    check_value("ff_still_full", fifo_full, 1);
    wr_ready = 1'b1;
    wait_idle("ff", 300, cyc);
    check_value("ff_xfers", n_xfers - base, 20);
    check_value("ff_end_empty", fifo_empty, 1);

    // Clipping at the right edge
    base = n_xfers;
    for (int a = 306555; a <= 306559; a++) enq(a, 1'b1);
    push_seg(635, 478, 645, 478, 1'b1);
    wait_idle("clip", 50, cyc);
    check_value("clip_cycles", cyc, 13);
    check_value("clip_xfers", n_xfers - base, 5);

    // Clear requested mid-segment, then reset mid-clear
    enq_model(0, 100, 19, 100, 1'b1);
    push_seg(0, 100, 19, 100, 1'b1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    clear_buffer = 1'b1;
    @(posedge clk);
    #1;
    clear_buffer = 1'b0;
    for (int a = 0; a < 40; a++) enq(a, 1'b0);
    // Queued behind the clear; discarded by the reset below.
    push_seg(10, 10, 12, 10, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check_value("clr_drain", exp_q.size(), 0);
    check_value("clr_active_en", wr_en, 1);
    check_value("clr_fifo_queued", fifo_empty, 0);
    check_value("clr_not_waiting", waiting, 0);
    rst = 1'b1;
    #1;
    check_value("mid_rst_wr_en", wr_en, 0);
    check_value("mid_rst_empty", fifo_empty, 1);
    check_value("mid_rst_waiting", waiting, 1);
    check_value("mid_rst_addr", wr_addr, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Degenerate segment after reset: exactly one pixel
    base = n_xfers;
    enq(5, 1'b1);
    push_seg(5, 0, 5, 0, 1'b1);
    wait_idle("degen", 50, cyc);
    check_value("degen_cycles", cyc, 3);
    check_value("degen_xfers", n_xfers - base, 1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_raster_queue.md
# line_raster_queue

Parametrised line rasteriser that accepts queued segment requests and writes their pixels into the frame-buffer RAM through a ready/valid write port. It replaces the single-segment drawer in the line-drawing path and adds a multi-entry segment FIFO, a per-segment colour, screen clipping, write back-pressure and a queued clear. It sits between the command sources (buttons, motion/projection logic) and the dual-port frame buffer that the VGA scan-out reads.

## Interface
- P_X_COORD_W, 11, x coordinate width, unsigned.
- P_Y_COORD_W, 11, y coordinate width, unsigned.
- P_SCREEN_W, 640, visible width in pixels.
- P_SCREEN_H, 480, visible height in pixels.
- P_DATA_W, 1, pixel/colour width.
- P_LOG2_RAM_DEPTH, 19, frame-buffer address width.
- P_LOG2_FIFO_DEPTH, 3, segment FIFO holds 2^P_LOG2_FIFO_DEPTH entries.
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_x0, i_x1  in  P_X_COORD_W  segment endpoint x.
- i_y0, i_y1  in  P_Y_COORD_W  segment endpoint y.
- i_color  in  P_DATA_W  segment colour.
- i_load_fifo  in  1  push {x0,y0,x1,y1,color}; single-cycle strobe.
- i_clear_buffer  in  1  request a full-screen clear; single-cycle strobe.
- o_fifo_full  out  1  FIFO full.
- o_fifo_empty  out  1  FIFO empty.
- o_overflow  out  1  one-cycle pulse: push dropped because the FIFO was full.
- o_waiting  out  1  state is IDLE, the FIFO is empty and no clear is pending.
- o_wr_en  out  1  write valid.
- i_wr_ready  in  1  frame buffer accepts the write.
- o_wr_addr  out  P_LOG2_RAM_DEPTH  y*P_SCREEN_W + x.
- o_wr_data  out  P_DATA_W  pixel value.

## Operation
- FIFO: a push is accepted when i_load_fifo=1 and o_fifo_full=0. If the FIFO is full, the push is dropped and o_overflow pulses on the next cycle. Full and empty are registered. A push while full is dropped even if a pop happens in the same cycle. A push and a pop in the same cycle when the FIFO is not full are both accepted.
- i_clear_buffer sets a clear_pending flag. The flag is taken in IDLE and has priority over popping the FIFO. A segment already being drawn always completes first.
- State machine:
  - IDLE: if clear_pending, go to CLEAR with the address counter at 0. Otherwise, if the FIFO is not empty, pop and go to LOAD.
  - LOAD: latch the head entry and compute:
    - dx = |x1-x0|
    - dy = -|y1-y0|
    - sx = (x1>=x0) ? +1 : -1
    - sy = (y1>=y0) ? +1 : -1
    - err = dx+dy
    - Then go to DRAW.
  - DRAW: the current pixel is (x,y).
    - If x<P_SCREEN_W and y<P_SCREEN_H, drive o_wr_en=1 and hold the pixel until i_wr_ready=1.
    - If the pixel is off-screen, suppress the write (o_wr_en=0) and step anyway, taking one cycle.
    - On transfer or skip: if (x,y)==(x1,y1), go to IDLE. Otherwise step:
      - e2 = 2*err
      - if e2>=dy: err+=dy, x+=sx
      - if e2<=dx: err+=dx, y+=sy
  - CLEAR: write 0 to addresses 0..P_SCREEN_W*P_SCREEN_H-1, one per accepted transfer. Go to IDLE after the last address is accepted and clear clear_pending.
- Arithmetic: err, dx and dy are signed with width max(P_X_COORD_W,P_Y_COORD_W)+2. Address uses full-precision multiply-add truncated to P_LOG2_RAM_DEPTH.
- A degenerate segment (x0==x1 and y0==y1) writes exactly one pixel.
- Both endpoints are written.

## Timing
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0
  - o_fifo_full=0, o_fifo_empty=1
  - o_overflow=0, o_waiting=1
  - state IDLE, FIFO flushed, clear_pending=0
- Reset during DRAW or CLEAR aborts immediately. The remaining pixels and the queued entries are discarded.
- Write handshake: a transfer occurs on a rising edge with o_wr_en=1 and i_wr_ready=1. o_wr_addr and o_wr_data are stable while o_wr_en=1 and i_wr_ready=0.
- Latency: with the block idle and the FIFO empty, a push sampled at edge E produces o_wr_en=1 from edge E+2. The sequence is pop at E+1, then LOAD to DRAW at E+2.
- Throughput: one pixel per cycle while i_wr_ready=1. A segment of N pixels occupies N DRAW cycles. There are 2 bubble cycles (IDLE and LOAD) between segments.
- Clear takes P_SCREEN_W*P_SCREEN_H cycles plus stall cycles.
- o_waiting rises on the edge after the final transfer when nothing is queued.

## Test plan
- Horizontal line: push (10,5)->(13,5), color 1, i_wr_ready=1 → addresses 3210,3211,3212,3213 on consecutive cycles; first o_wr_en at push+2; then o_waiting=1.
- Steep reverse line: push (3,7)->(1,2) → pixels (3,7),(3,6),(2,5),(2,4),(1,3),(1,2); error term matches a Bresenham reference model.
- Back-pressure: i_wr_ready toggles 1,0,0,1 → o_wr_addr and o_wr_data are held during stalls, no pixel is lost or duplicated, and the total transfer count equals the pixel count.
- FIFO full: with P_LOG2_FIFO_DEPTH=3, push 9 segments back-to-back while i_wr_ready=0 → o_fifo_full=1 after the 8th push is registered, and the 9th push raises o_overflow for 1 cycle. Releasing ready draws 8 segments in push order.
- Clipping: push (635,478)->(645,478) → only x=635..639 are written (addresses 306555..306559), and the 6 off-screen steps are skipped with o_wr_en=0.
- Clear and reset:
  - Pulse i_clear_buffer mid-segment → the segment completes, then 307200 zero writes to addresses 0..307199 run ahead of the queued segments.
  - Asserting i_reset mid-clear → o_wr_en=0 immediately, o_fifo_empty=1, o_waiting=1.
